cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
// Sits between the instruction cache (demand and OBL-prefetch line fills) and the data cache,
// and the single cacheline adaptor port to physical memory.
// Accepts full 256-bit line requests from both caches and grants one at a time.
// Latches the winning request and drives it to memory until mem_resp.
// Routes the returned line and a one-cycle resp pulse back to the owner.
// PARAMETERS
// ADDR_W  32   address width (line-aligned addresses; bits [4:0] forwarded unchanged)
// LINE_W  256  cacheline width
// PORTS
// clk          in   1       clock, all state on rising edge
// rst          in   1       asynchronous, active-high reset
// i_read       in   1       i-cache line read request, held until i_resp
// i_prefetch   in   1       qualifies i_read as an OBL prefetch (not a demand miss)
// i_address    in   ADDR_W  i-cache line address
// i_rdata      out  LINE_W  line returned to i-cache
// i_resp       out  1       one-cycle completion pulse to i-cache
// d_read       in   1       d-cache line read request, held until d_resp
// d_write      in   1       d-cache writeback request, held until d_resp
// d_address    in   ADDR_W  d-cache line address
// d_wdata      in   LINE_W  writeback line
// d_rdata      out  LINE_W  line returned to d-cache
// d_resp       out  1       one-cycle completion pulse to d-cache
// mem_read     out  1       read to cacheline adaptor
// mem_write    out  1       write to cacheline adaptor
// mem_address  out  ADDR_W  address to adaptor
// mem_wdata    out  LINE_W  write line to adaptor
// mem_rdata    in   LINE_W  line from adaptor, valid with mem_resp
// mem_resp     in   1       adaptor completion, one cycle
// BEHAVIOUR
// - FSM states: IDLE, SERVE_I, SERVE_D, GAP.
//   Reset -> IDLE; last_grant = D; latches = 0; all outputs 0.
// - IDLE: arbitrate on the current cycle's inputs. Latch the winner's address, wdata and op into
//   req regs, then go to SERVE_x on the next edge. No mem_* asserted in IDLE.
// - Priority:
//   - d_read/d_write beat a prefetch i_read (i_prefetch=1) always.
//   - A demand i_read vs. a D request: round-robin; grant the client not in last_grant.
//   - Only one requester: it wins.
//   - No requester: stay IDLE.
// - SERVE_x:
//   - mem_read/mem_write and mem_address/mem_wdata come only from the latched regs.
//     Client input changes are ignored until completion.
//   - Minimum latency: request in cycle t, mem_* asserted at t+1.
// - Completion: on mem_resp in SERVE_x:
//   - x_resp = 1 in the same cycle, combinationally.
//   - x_rdata = mem_rdata in the same cycle. i_rdata and d_rdata pass mem_rdata at all times;
//     only the resp pulses are gated.
//   - Update last_grant = x, then go to GAP.
// - GAP: exactly one cycle; all requests ignored, mem_* = 0; then IDLE.
//   This guarantees a client's held request is never re-granted after its resp.
// - d_read & d_write both high is illegal. Treat it as a write and fire an assertion.
// - A prefetch already in SERVE_I is never pre-empted by a later D request; it runs to mem_resp.
// - mem_resp outside SERVE_x is ignored; no resp pulse is produced.
// - rst asserted mid-transaction:
//   - mem_read, mem_write, i_resp and d_resp drop immediately (async).
//   - FSM goes to IDLE.
//   - The in-flight line is discarded; the adaptor is reset by the same rst.
// - Never assert mem_read and mem_write together.
// - Never assert i_resp and d_resp in the same cycle.
// STRUCTURE
// - Shared package rv32i_types gains: typedef enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D, ARB_GAP} arb_state_t;
//   and localparam ARB_GRANT_I = 1'b0, ARB_GRANT_D = 1'b1.
// - Request latch is a single sub-module instance: register #(.width(ADDR_W+LINE_W+2)) req_latch.
//   It holds address, wdata, read and write.
// - FSM and arbitration comb logic stay in this module. No other sub-modules.
// TESTING
// - Lone i_read, i_address=32'h0000_0040: mem_read at t+1 with mem_address=32'h40.
//   mem_resp 4 cycles later with data D -> i_resp=1 and i_rdata=D for exactly one cycle.
// - d_write at 32'h0000_1000, wdata=256'hA5..A5: mem_write=1 with latched data.
//   Toggle d_wdata during SERVE_D -> mem_wdata stays A5..A5 until d_resp.
// - Same-cycle demand i_read(0x20) and d_read(0x100) from reset (last_grant=D) -> I served first.
//   After GAP, D served. Repeat with both held -> strict alternation.
// - Prefetch i_read (i_prefetch=1, 0x60) and d_read(0x200) same cycle -> D granted first.
//   If the prefetch is already in SERVE_I when d_read rises -> prefetch completes first.
// - Hold i_read high through i_resp: no second mem_read in GAP; regrant occurs only from IDLE.
// - Assert rst two cycles into SERVE_D -> mem_read=0 the same cycle, no d_resp, state IDLE.
//   A late mem_resp after reset produces no resp.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the cache/memory path: arbiter FSM states and grant encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D,
        ARB_GAP
    } arb_state_t;

    localparam logic ARB_GRANT_I = 1'b0;
    localparam logic ARB_GRANT_D = 1'b1;

endpackage

// File: rtl/register.sv
// Loadable register with asynchronous active-high clear.
module register #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [width-1:0] i_data,
    output logic [width-1:0] o_data
);

    logic [width-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_data <= '0;
        else if (i_load) r_data <= i_data;
    end

    assign o_data = r_data;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates i-cache and d-cache line requests onto one cacheline adaptor port,
// holding the winning request in a latch until the adaptor responds.
module cache_mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_prefetch,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int REQ_W = ADDR_W + LINE_W + 2;

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_last_grant;
    logic              w_d_req;
    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_load;
    logic [REQ_W-1:0]  w_req_in;
    logic [REQ_W-1:0]  w_req_q;
    logic [ADDR_W-1:0] w_lat_addr;
    logic [LINE_W-1:0] w_lat_wdata;
    logic              w_lat_read;
    logic              w_lat_write;

    assign w_d_req   = d_read | d_write;
    // Prefetches always yield to D; a demand fetch contends round-robin.
    assign w_grant_d = w_d_req & (~i_read | i_prefetch | (r_last_grant == ARB_GRANT_I));
    assign w_grant_i = i_read & ~w_grant_d;

    register #(.width(REQ_W)) req_latch (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (w_req_in),
        .o_data (w_req_q)
    );

    assign {w_lat_addr, w_lat_wdata, w_lat_read, w_lat_write} = w_req_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= ARB_GRANT_D;
        end else begin
            r_state <= w_next_state;
            if (i_resp)      r_last_grant <= ARB_GRANT_I;
            else if (d_resp) r_last_grant <= ARB_GRANT_D;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_req_in     = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_d) begin
                    w_load       = 1'b1;
                    // Simultaneous read+write is treated as a writeback.
                    w_req_in     = {d_address, d_wdata, d_read & ~d_write, d_write};
                    w_next_state = ARB_SERVE_D;
                end else if (w_grant_i) begin
                    w_load       = 1'b1;
                    w_req_in     = {i_address, {LINE_W{1'b0}}, 1'b1, 1'b0};
                    w_next_state = ARB_SERVE_I;
                end
            end
            ARB_SERVE_I: begin
                mem_read  = w_lat_read;
                mem_write = w_lat_write;
                i_resp    = mem_resp;
                if (mem_resp) w_next_state = ARB_GAP;
            end
            ARB_SERVE_D: begin
                mem_read  = w_lat_read;
                mem_write = w_lat_write;
                d_resp    = mem_resp;
                if (mem_resp) w_next_state = ARB_GAP;
            end
            ARB_GAP:  w_next_state = ARB_IDLE;
            default:  w_next_state = ARB_IDLE;
        endcase
    end

    assign mem_address = w_lat_addr;
    assign mem_wdata   = w_lat_wdata;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write))
        else $error("d_read and d_write asserted together");
    a_mem_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write))
        else $error("mem_read and mem_write asserted together");

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: vector table for single grants plus
// hand sequences for alternation, prefetch non-preemption, wdata hold and reset.
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read, i_prefetch;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read, d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    int n_checks = 0;
    int n_fails  = 0;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_prefetch(i_prefetch), .i_address(i_address),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ir, ip, dr, dw;
        logic [31:0] ia, da;
        logic        er, ew;
        logic [31:0] ea;
        logic        own_i;
    } vec_t;

    vec_t vecs[8];

    localparam logic [LINE_W-1:0] WD_A5 = {32{8'hA5}};
    localparam logic [LINE_W-1:0] WD_5A = {32{8'h5A}};

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        i_read = 0; i_prefetch = 0; i_address = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 0;
    endtask

    task automatic do_reset;
        rst = 1;
        clear_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    task automatic run_vec(input int k);
        logic [LINE_W-1:0] data;
        data = {8{32'hDEADBEEF}} ^ LINE_W'(k);
        do_reset();
        i_read = vecs[k].ir; i_prefetch = vecs[k].ip; i_address = vecs[k].ia;
        d_read = vecs[k].dr; d_write = vecs[k].dw; d_address = vecs[k].da;
        d_wdata = WD_A5;
        #1;
        chk($sformatf("v%0d_idle_rd", k), mem_read, 1'b0);
        tick();
        chk($sformatf("v%0d_rd", k), mem_read, vecs[k].er);
        chk($sformatf("v%0d_wr", k), mem_write, vecs[k].ew);
        chk($sformatf("v%0d_addr", k), mem_address, vecs[k].ea);
        if (vecs[k].ew) chk($sformatf("v%0d_wdata", k), mem_wdata, WD_A5);
        tick(); tick(); tick();
        chk($sformatf("v%0d_hold_rd", k), mem_read, vecs[k].er);
        mem_resp = 1; mem_rdata = data;
        #1;
        chk($sformatf("v%0d_iresp", k), i_resp, vecs[k].own_i);
        chk($sformatf("v%0d_dresp", k), d_resp, !vecs[k].own_i);
        chk($sformatf("v%0d_rdata", k), vecs[k].own_i ? i_rdata : d_rdata, data);
        tick();
        clear_inputs();
        #1;
        chk($sformatf("v%0d_gap_resp", k), {i_resp, d_resp}, 2'b00);
        chk($sformatf("v%0d_gap_mem", k), {mem_read, mem_write}, 2'b00);
        tick();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        //          ir    ip    dr    dw    ia        da         er    ew    ea         own_i
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h40,   32'h0,     1'b1, 1'b0, 32'h40,    1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,    32'h100,   1'b1, 1'b0, 32'h100,   1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h1000,  1'b0, 1'b1, 32'h1000,  1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h20,   32'h100,   1'b1, 1'b0, 32'h20,    1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h60,   32'h200,   1'b1, 1'b0, 32'h200,   1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h80,   32'h0,     1'b1, 1'b0, 32'h80,    1'b1};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h20,   32'h300,   1'b1, 1'b0, 32'h20,    1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hA0,   32'h400,   1'b0, 1'b1, 32'h400,   1'b0};

        // Reset state
        do_reset();
        #1;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_address, 32'h0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);

        for (int k = 0; k < 8; k++) run_vec(k);

        // Writeback data is held from the latch while client wdata changes
        do_reset();
        d_write = 1; d_address = 32'h1000; d_wdata = WD_A5;
        tick();
        chk("wb_write", mem_write, 1'b1);
        chk("wb_read", mem_read, 1'b0);
        chk("wb_wdata0", mem_wdata, WD_A5);
        d_wdata = WD_5A; d_address = 32'hFFFF_FFE0;
        tick();
        chk("wb_wdata1", mem_wdata, WD_A5);
        chk("wb_addr1", mem_address, 32'h1000);
        tick();
        mem_resp = 1;
        #1;
        chk("wb_dresp", d_resp, 1'b1);
        chk("wb_wdata2", mem_wdata, WD_A5);
        tick();
        clear_inputs();
        tick();

        // Both held: strict alternation I, D, I, D with no regrant in GAP
        do_reset();
        i_read = 1; i_address = 32'h20; d_read = 1; d_address = 32'h100;
        for (int g = 0; g < 4; g++) begin
            logic exp_i;
            exp_i = (g % 2 == 0);
            tick();
            chk($sformatf("alt%0d_rd", g), mem_read, 1'b1);
            chk($sformatf("alt%0d_addr", g), mem_address, exp_i ? 32'h20 : 32'h100);
            tick();
            mem_resp = 1; mem_rdata = {8{32'h0BADF00D}};
            #1;
            chk($sformatf("alt%0d_iresp", g), i_resp, exp_i);
            chk($sformatf("alt%0d_dresp", g), d_resp, !exp_i);
            tick();
            mem_resp = 0;
            #1;
            chk($sformatf("alt%0d_gap_rd", g), mem_read, 1'b0);
            tick();
            chk($sformatf("alt%0d_idle_rd", g), mem_read, 1'b0);
        end
        clear_inputs();
        tick();

        // Prefetch already in service is not pre-empted by a later d_read
        do_reset();
        i_read = 1; i_prefetch = 1; i_address = 32'h60;
        tick();
        chk("pf_addr0", mem_address, 32'h60);
        d_read = 1; d_address = 32'h200;
        tick(); tick();
        chk("pf_addr1", mem_address, 32'h60);
        chk("pf_rd1", mem_read, 1'b1);
        mem_resp = 1; mem_rdata = {8{32'hCAFEF00D}};
        #1;
        chk("pf_iresp", i_resp, 1'b1);
        chk("pf_dresp", d_resp, 1'b0);
        chk("pf_irdata", i_rdata, {8{32'hCAFEF00D}});
        tick();
        mem_resp = 0; i_read = 0; i_prefetch = 0;
        #1;
        chk("pf_gap_rd", mem_read, 1'b0);
        tick();
        tick();
        chk("pf_d_addr", mem_address, 32'h200);
        chk("pf_d_rd", mem_read, 1'b1);
        mem_resp = 1;
        #1;
        chk("pf_d_dresp", d_resp, 1'b1);
        chk("pf_d_iresp", i_resp, 1'b0);
        tick();
        clear_inputs();
        tick();

        // Reset two cycles into SERVE_D; late mem_resp must be ignored
        do_reset();
        d_read = 1; d_address = 32'h100;
        tick();
        chk("mr_rd0", mem_read, 1'b1);
        tick(); tick();
        rst = 1;
        #1;
        chk("mr_rd_async", mem_read, 1'b0);
        chk("mr_dresp_async", d_resp, 1'b0);
        d_read = 0;
        mem_resp = 1;
        tick();
        rst = 0;
        #1;
        chk("mr_late_resp", {i_resp, d_resp}, 2'b00);
        tick();
        chk("mr_late_rd", mem_read, 1'b0);
        chk("mr_late_resp2", {i_resp, d_resp}, 2'b00);
        mem_resp = 0;
        d_read = 1; d_address = 32'h180;
        tick();
        chk("mr_regrant_rd", mem_read, 1'b1);
        chk("mr_regrant_addr", mem_address, 32'h180);
        mem_resp = 1;
        #1;
        chk("mr_regrant_dresp", d_resp, 1'b1);
        tick();
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
